// File: rtl/duty_ctrl_pkg.sv
// Shared types, default constants and saturating step arithmetic for duty_step_ctrl.
package duty_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_INC_HOLD = 2'd1,
        ST_DEC_HOLD = 2'd2,
        ST_LOCK     = 2'd3
    } duty_state_e;

    localparam int DEF_DUTY_W     = 8;
    localparam int DEF_DUTY_RESET = 128;
    localparam int DEF_STEP       = 16;

    // One extra bit of headroom so the add cannot wrap before the clamp.
    function automatic logic [31:0] sat_step(
        input logic [31:0] val,
        input logic [31:0] step,
        input logic [31:0] max_val,
        input logic        up
    );
        logic [32:0] sum;
        sum = {1'b0, val} + {1'b0, step};
        if (up) begin
            if (sum > {1'b0, max_val}) begin
                sat_step = max_val;
            end else begin
                sat_step = sum[31:0];
            end
        end else begin
            if (step > val) begin
                sat_step = 32'd0;
            end else begin
                sat_step = val - step;
            end
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-level debounce counter and press (rise) detector
// for one raw push-button line.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int LP_CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [LP_CNT_W-1:0] LP_CNT_LAST = LP_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic [LP_CNT_W-1:0] r_cnt;
    logic                r_level;
    logic                r_prev;
    logic [1:0]          r_fill;
    logic                r_armed;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Flip the debounced level only after the synced level has differed long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 != r_level) begin
            if (r_cnt == LP_CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Edge history, plus arming: a button held through reset must be seen released
    // (once the synchroniser holds real data) before its presses count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= 1'b0;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_prev <= r_level;
            r_fill <= {r_fill[0], 1'b1};
            if (r_fill[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_level & ~r_prev & r_armed;

endmodule

// File: rtl/duty_step_ctrl.sv
// Debounced push-button front-end stepping a saturating PWM duty register.
// Optional auto-repeat while a button is held: define DUTY_AUTOREPEAT_EN.
module duty_step_ctrl
    import duty_ctrl_pkg::*;
#(
    parameter int DUTY_W          = DEF_DUTY_W,
    parameter int DUTY_RESET      = DEF_DUTY_RESET,
    parameter int STEP            = DEF_STEP,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 1024,
    parameter int REPEAT_PERIOD   = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              increase_duty,
    input  logic              decrease_duty,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_update,
    output logic              at_max,
    output logic              at_min
);

    localparam logic [DUTY_W-1:0] LP_MAX = {DUTY_W{1'b1}};
    localparam logic [DUTY_W-1:0] LP_RST = DUTY_W'(DUTY_RESET);

    logic              w_inc_lvl;
    logic              w_inc_rise;
    logic              w_dec_lvl;
    logic              w_dec_rise;
    logic              w_rep_fire;
    logic              w_do_up;
    logic              w_do_dn;
    logic [DUTY_W-1:0] w_up_val;
    logic [DUTY_W-1:0] w_dn_val;

    duty_state_e       r_state;
    logic [DUTY_W-1:0] r_duty;
    logic              r_update;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (increase_duty),
        .o_level (w_inc_lvl),
        .o_rise  (w_inc_rise)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (decrease_duty),
        .o_level (w_dec_lvl),
        .o_rise  (w_dec_rise)
    );

`ifdef DUTY_AUTOREPEAT_EN
    localparam int LP_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int LP_REP_W   = (LP_REP_MAX > 2) ? $clog2(LP_REP_MAX) : 1;

    logic                r_rep_active;
    logic [LP_REP_W-1:0] r_rep_cnt;
    logic                w_hold_stay;
    logic                w_rep_due;

    assign w_hold_stay = ena & (((r_state == ST_INC_HOLD) & w_inc_lvl & ~w_dec_lvl) |
                                ((r_state == ST_DEC_HOLD) & w_dec_lvl & ~w_inc_lvl));
    assign w_rep_due   = r_rep_active ? (r_rep_cnt == LP_REP_W'(REPEAT_PERIOD - 1))
                                      : (r_rep_cnt == LP_REP_W'(REPEAT_DELAY - 1));
    assign w_rep_fire  = w_hold_stay & w_rep_due;

    // Hold timer: initial delay first, then the repeat period; cleared whenever the hold ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt    <= '0;
            r_rep_active <= 1'b0;
        end else if (!w_hold_stay) begin
            r_rep_cnt    <= '0;
            r_rep_active <= 1'b0;
        end else if (w_rep_due) begin
            r_rep_cnt    <= '0;
            r_rep_active <= 1'b1;
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    assign w_up_val = DUTY_W'(sat_step(32'(r_duty), 32'(STEP), 32'(LP_MAX), 1'b1));
    assign w_dn_val = DUTY_W'(sat_step(32'(r_duty), 32'(STEP), 32'(LP_MAX), 1'b0));

    // Step requests; a press with the other button already down never steps.
    always_comb begin
        w_do_up = 1'b0;
        w_do_dn = 1'b0;
        if (ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_inc_rise && !w_dec_lvl) begin
                        w_do_up = 1'b1;
                    end else if (w_dec_rise && !w_inc_lvl) begin
                        w_do_dn = 1'b1;
                    end else begin
                        w_do_up = 1'b0;
                    end
                end
                ST_INC_HOLD: w_do_up = w_rep_fire;
                ST_DEC_HOLD: w_do_dn = w_rep_fire;
                default:     w_do_up = 1'b0;
            endcase
        end else begin
            w_do_up = 1'b0;
        end
    end

    // Button-hold state machine; ena low parks it in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (!ena) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_inc_lvl && w_dec_lvl) begin
                        r_state <= ST_LOCK;
                    end else if (w_inc_rise) begin
                        r_state <= ST_INC_HOLD;
                    end else if (w_dec_rise) begin
                        r_state <= ST_DEC_HOLD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_INC_HOLD: begin
                    if (w_dec_lvl) begin
                        r_state <= ST_LOCK;
                    end else if (!w_inc_lvl) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_INC_HOLD;
                    end
                end
                ST_DEC_HOLD: begin
                    if (w_inc_lvl) begin
                        r_state <= ST_LOCK;
                    end else if (!w_dec_lvl) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_DEC_HOLD;
                    end
                end
                ST_LOCK: begin
                    if (!w_inc_lvl && !w_dec_lvl) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_LOCK;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Duty register; the update strobe fires only on a real value change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty   <= LP_RST;
            r_update <= 1'b0;
        end else if (w_do_up && (w_up_val != r_duty)) begin
            r_duty   <= w_up_val;
            r_update <= 1'b1;
        end else if (w_do_dn && (w_dn_val != r_duty)) begin
            r_duty   <= w_dn_val;
            r_update <= 1'b1;
        end else begin
            r_update <= 1'b0;
        end
    end

    assign duty        = r_duty;
    assign duty_update = r_update;
    assign at_max      = (r_duty == LP_MAX);
    assign at_min      = (r_duty == {DUTY_W{1'b0}});

endmodule

// File: tb/tb_duty_step_ctrl.sv
// Directed self-checking bench for duty_step_ctrl (DEBOUNCE_CYCLES=4, STEP=16, reset 128).
module tb_duty_step_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       increase_duty;
    logic       decrease_duty;
    logic [7:0] duty;
    logic       duty_update;
    logic       at_max;
    logic       at_min;

    int n_pass  = 0;
    int n_total = 0;
    int upd_cnt = 0;

    always #5 clk = ~clk;

    duty_step_ctrl #(
        .DUTY_W          (8),
        .DUTY_RESET      (128),
        .STEP            (16),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (32),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .increase_duty (increase_duty),
        .decrease_duty (decrease_duty),
        .duty          (duty),
        .duty_update   (duty_update),
        .at_max        (at_max),
        .at_min        (at_min)
    );

    always @(negedge clk) begin
        if (duty_update === 1'b1) upd_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_inc();
        increase_duty = 1'b1;
        tick(8);
        increase_duty = 1'b0;
        tick(8);
    endtask

    task automatic press_dec();
        decrease_duty = 1'b1;
        tick(8);
        decrease_duty = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        tick(2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_total++;
        if (duty !== 8'd128) $display("FAIL reset_duty: got %0d want 128", duty); else n_pass++;
        n_total++;
        if (duty_update !== 1'b0) $display("FAIL reset_update: got %b want 0", duty_update); else n_pass++;
        n_total++;
        if (at_max !== 1'b0) $display("FAIL reset_at_max: got %b want 0", at_max); else n_pass++;
        n_total++;
        if (at_min !== 1'b0) $display("FAIL reset_at_min: got %b want 0", at_min); else n_pass++;
        #2 rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_increase();
        int u0;
        u0 = upd_cnt;
        increase_duty = 1'b1;
        tick(6);
        n_total++;
        if (duty !== 8'd128) $display("FAIL inc_early: got %0d want 128", duty); else n_pass++;
        tick(1);
        n_total++;
        if (duty !== 8'd144) $display("FAIL inc_latency: got %0d want 144", duty); else n_pass++;
        n_total++;
        if (duty_update !== 1'b1) $display("FAIL inc_pulse: got %b want 1", duty_update); else n_pass++;
        tick(1);
        n_total++;
        if (duty_update !== 1'b0) $display("FAIL inc_pulse_len: got %b want 0", duty_update); else n_pass++;
        tick(12);
        increase_duty = 1'b0;
        tick(10);
        n_total++;
        if (duty !== 8'd144) $display("FAIL inc_hold: got %0d want 144", duty); else n_pass++;
        n_total++;
        if (upd_cnt - u0 !== 1) $display("FAIL inc_pulses: got %0d want 1", upd_cnt - u0); else n_pass++;
    endtask

    task automatic test_glitch();
        int u0;
        u0 = upd_cnt;
        increase_duty = 1'b1;
        tick(3);
        increase_duty = 1'b0;
        tick(10);
        n_total++;
        if (duty !== 8'd144) $display("FAIL glitch_duty: got %0d want 144", duty); else n_pass++;
        n_total++;
        if (upd_cnt - u0 !== 0) $display("FAIL glitch_pulses: got %0d want 0", upd_cnt - u0); else n_pass++;
    endtask

    task automatic test_saturation();
        int u0;
        for (int i = 0; i < 6; i++) press_inc();
        n_total++;
        if (duty !== 8'd240) $display("FAIL sat_pre: got %0d want 240", duty); else n_pass++;
        u0 = upd_cnt;
        press_inc();
        n_total++;
        if (duty !== 8'd255) $display("FAIL sat_max_duty: got %0d want 255", duty); else n_pass++;
        n_total++;
        if (at_max !== 1'b1) $display("FAIL sat_at_max: got %b want 1", at_max); else n_pass++;
        n_total++;
        if (upd_cnt - u0 !== 1) $display("FAIL sat_max_pulse: got %0d want 1", upd_cnt - u0); else n_pass++;
        u0 = upd_cnt;
        press_inc();
        n_total++;
        if (duty !== 8'd255 || upd_cnt - u0 !== 0)
            $display("FAIL sat_max_noop: got duty %0d pulses %0d want 255 0", duty, upd_cnt - u0);
        else n_pass++;
        for (int i = 0; i < 15; i++) press_dec();
        n_total++;
        if (duty !== 8'd15) $display("FAIL sat_down_15: got %0d want 15", duty); else n_pass++;
        u0 = upd_cnt;
        press_dec();
        n_total++;
        if (duty !== 8'd0 || at_min !== 1'b1 || upd_cnt - u0 !== 1)
            $display("FAIL sat_min: got duty %0d at_min %b pulses %0d want 0 1 1", duty, at_min, upd_cnt - u0);
        else n_pass++;
        u0 = upd_cnt;
        press_dec();
        n_total++;
        if (duty !== 8'd0 || upd_cnt - u0 !== 0)
            $display("FAIL sat_min_noop: got duty %0d pulses %0d want 0 0", duty, upd_cnt - u0);
        else n_pass++;
    endtask

    task automatic test_lock();
        int u0;
        press_inc();
        press_inc();
        u0 = upd_cnt;
        increase_duty = 1'b1;
        decrease_duty = 1'b1;
        tick(10);
        increase_duty = 1'b0;
        decrease_duty = 1'b0;
        tick(10);
        n_total++;
        if (duty !== 8'd32 || upd_cnt - u0 !== 0)
            $display("FAIL lock_simul: got duty %0d pulses %0d want 32 0", duty, upd_cnt - u0);
        else n_pass++;
        u0 = upd_cnt;
        increase_duty = 1'b1;
        tick(10);
        decrease_duty = 1'b1;
        tick(10);
        n_total++;
        if (duty !== 8'd48 || upd_cnt - u0 !== 1)
            $display("FAIL lock_hold: got duty %0d pulses %0d want 48 1", duty, upd_cnt - u0);
        else n_pass++;
        increase_duty = 1'b0;
        decrease_duty = 1'b0;
        tick(10);
        press_dec();
        n_total++;
        if (duty !== 8'd32) $display("FAIL lock_release: got %0d want 32", duty); else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        int u0;
        increase_duty = 1'b1;
        tick(10);
        n_total++;
        if (duty !== 8'd48) $display("FAIL midrst_pre: got %0d want 48", duty); else n_pass++;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_total++;
        if (duty !== 8'd128) $display("FAIL midrst_duty: got %0d want 128", duty); else n_pass++;
        #2 rst_n = 1'b1;
        u0 = upd_cnt;
        tick(20);
        n_total++;
        if (duty !== 8'd128 || upd_cnt - u0 !== 0)
            $display("FAIL midrst_held: got duty %0d pulses %0d want 128 0", duty, upd_cnt - u0);
        else n_pass++;
        increase_duty = 1'b0;
        tick(10);
        press_inc();
        n_total++;
        if (duty !== 8'd144) $display("FAIL midrst_repress: got %0d want 144", duty); else n_pass++;
    endtask

    task automatic test_ena();
        int u0;
        u0 = upd_cnt;
        ena = 1'b0;
        press_inc();
        n_total++;
        if (duty !== 8'd144 || upd_cnt - u0 !== 0)
            $display("FAIL ena_low_press: got duty %0d pulses %0d want 144 0", duty, upd_cnt - u0);
        else n_pass++;
        increase_duty = 1'b1;
        tick(10);
        ena = 1'b1;
        tick(10);
        n_total++;
        if (duty !== 8'd144) $display("FAIL ena_rise_held: got %0d want 144", duty); else n_pass++;
        increase_duty = 1'b0;
        tick(10);
        press_inc();
        n_total++;
        if (duty !== 8'd160) $display("FAIL ena_repress: got %0d want 160", duty); else n_pass++;
    endtask

    task automatic test_long_hold();
        int u0;
        int exp_duty;
        int exp_pulses;
`ifdef DUTY_AUTOREPEAT_EN
        exp_duty   = 240;
        exp_pulses = 5;
`else
        exp_duty   = 176;
        exp_pulses = 1;
`endif
        u0 = upd_cnt;
        increase_duty = 1'b1;
        tick(60);
        increase_duty = 1'b0;
        tick(15);
        n_total++;
        if (duty !== 8'(exp_duty)) $display("FAIL long_hold_duty: got %0d want %0d", duty, exp_duty); else n_pass++;
        n_total++;
        if (upd_cnt - u0 !== exp_pulses)
            $display("FAIL long_hold_pulses: got %0d want %0d", upd_cnt - u0, exp_pulses);
        else n_pass++;
    endtask

    initial begin
        rst_n         = 1'b1;
        ena           = 1'b1;
        increase_duty = 1'b0;
        decrease_duty = 1'b0;
        #1;
        test_reset();
        test_increase();
        test_glitch();
        test_saturation();
        test_lock();
        test_reset_mid_hold();
        test_ena();
        test_long_hold();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
